// File: rtl/univ_reg.sv
// Universal register: hold, parallel load, shift left/right, up/down count and clear,
// with terminal-count, serial-out and a sticky overflow/underflow flag.
module univ_reg #(
    parameter int unsigned          WIDTH    = 4,
    parameter bit                   SATURATE = 1'b0,
    parameter logic [WIDTH-1:0]     INIT     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             tc,
    output logic             ovf
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_UP   = 3'b100,
        OP_DOWN = 3'b101,
        OP_CLR  = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    op_t              op;
    logic             up_lim;
    logic             dn_lim;
    logic             ovf_clr;
    logic [WIDTH-1:0] q_next;

    assign op = op_t'(mode);

    always_comb begin
        up_lim  = (op == OP_UP)   && (&q);
        dn_lim  = (op == OP_DOWN) && (q == '0);
        ovf_clr = (op == OP_LOAD) || (op == OP_CLR);
        tc      = ena && (up_lim || dn_lim);
    end

    always_comb begin
        q_next = q;
        case (op)
            OP_LOAD: q_next = d;
            OP_SHL:  q_next = {q[WIDTH-2:0], sin};
            OP_SHR:  q_next = {sin, q[WIDTH-1:1]};
            // Saturating counters simply hold at the limit; wrap is natural modulo arithmetic.
            OP_UP:   q_next = (up_lim && SATURATE) ? q : q + ONE;
            OP_DOWN: q_next = (dn_lim && SATURATE) ? q : q - ONE;
            OP_CLR:  q_next = '0;
            default: q_next = q;
        endcase
    end

    always_comb begin
        sout = 1'b0;
        case (op)
            OP_SHL:  sout = q[WIDTH-1];
            OP_SHR:  sout = q[0];
            default: sout = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= INIT;
            ovf <= 1'b0;
        end else if (ena) begin
            q <= q_next;
            if (ovf_clr)
                ovf <= 1'b0;
            else if (up_lim || dn_lim)
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_univ_reg.sv
// Scoreboard bench for univ_reg: three instances (4-bit wrap, 4-bit saturate, 8-bit wrap)
// driven with directed vectors; a negedge monitor pops and compares expectations.
module tb_univ_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=4, SATURATE=0, INIT=5
    logic       a_reset, a_ena, a_sin, a_sout, a_tc, a_ovf;
    logic [2:0] a_mode;
    logic [3:0] a_d, a_q;
    // Instance B: WIDTH=4, SATURATE=1, INIT=0
    logic       b_reset, b_ena, b_sin, b_sout, b_tc, b_ovf;
    logic [2:0] b_mode;
    logic [3:0] b_d, b_q;
    // Instance C: WIDTH=8, SATURATE=0, INIT=0
    logic       c_reset, c_ena, c_sin, c_sout, c_tc, c_ovf;
    logic [2:0] c_mode;
    logic [7:0] c_d, c_q;

    univ_reg #(.WIDTH(4), .SATURATE(1'b0), .INIT(4'h5)) dut_a (
        .clk(clk), .reset(a_reset), .ena(a_ena), .mode(a_mode), .d(a_d), .sin(a_sin),
        .q(a_q), .sout(a_sout), .tc(a_tc), .ovf(a_ovf)
    );
    univ_reg #(.WIDTH(4), .SATURATE(1'b1), .INIT(4'h0)) dut_b (
        .clk(clk), .reset(b_reset), .ena(b_ena), .mode(b_mode), .d(b_d), .sin(b_sin),
        .q(b_q), .sout(b_sout), .tc(b_tc), .ovf(b_ovf)
    );
    univ_reg #(.WIDTH(8), .SATURATE(1'b0), .INIT(8'h00)) dut_c (
        .clk(clk), .reset(c_reset), .ena(c_ena), .mode(c_mode), .d(c_d), .sin(c_sin),
        .q(c_q), .sout(c_sout), .tc(c_tc), .ovf(c_ovf)
    );

    typedef enum int {A_Q, A_OVF, A_TC, A_SOUT, B_Q, B_OVF, B_TC, C_Q, C_OVF, C_TC} sig_t;

    typedef struct {
        int          cyc;
        sig_t        sig;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    cyc = 0;
    int    applied = 0;
    int    miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(sig_t s);
        case (s)
            A_Q:    return 32'(a_q);
            A_OVF:  return 32'(a_ovf);
            A_TC:   return 32'(a_tc);
            A_SOUT: return 32'(a_sout);
            B_Q:    return 32'(b_q);
            B_OVF:  return 32'(b_ovf);
            B_TC:   return 32'(b_tc);
            C_Q:    return 32'(c_q);
            C_OVF:  return 32'(c_ovf);
            default: return 32'(c_tc);
        endcase
    endfunction

    // Monitor: every negedge, compare all expectations due in this cycle.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            item_t it;
            logic [31:0] act;
            it  = sb.pop_front();
            act = actual(it.sig);
            applied++;
            if (it.cyc != cyc || act !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %0h expected %0h (cycle %0d, due %0d)",
                         it.name, act, it.exp, cyc, it.cyc);
            end
        end
    end

    // Expectation on combinational outputs with the current inputs.
    task automatic exp_now(sig_t s, logic [31:0] v, string n);
        sb.push_back('{cyc, s, v, n});
    endtask

    // Expectation on state after the next rising edge.
    task automatic exp_next(sig_t s, logic [31:0] v, string n);
        sb.push_back('{cyc + 1, s, v, n});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {a_reset, b_reset, c_reset} = 3'b111;
        {a_ena, b_ena, c_ena}       = 3'b000;
        {a_sin, b_sin, c_sin}       = 3'b000;
        a_mode = 3'b000; b_mode = 3'b000; c_mode = 3'b000;
        a_d = '0; b_d = '0; c_d = '0;
        step();

        // Reset loads INIT and clears ovf, then disabled loads are ignored
        exp_next(A_Q, 32'h5, "rst_q");
        exp_next(A_OVF, 32'h0, "rst_ovf");
        exp_next(B_Q, 32'h0, "rst_b_q");
        exp_next(C_Q, 32'h0, "rst_c_q");
        step();
        applied++;
        if (a_q !== 4'h5 || a_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL direct_rst: q=%0h ovf=%0b", a_q, a_ovf);
        end
        {a_reset, b_reset, c_reset} = 3'b000;
        a_ena = 1'b0; a_mode = 3'b001; a_d = 4'hA;
        repeat (3) begin
            exp_now(A_TC, 32'h0, "dis_tc");
            exp_next(A_Q, 32'h5, "dis_hold_q");
            step();
        end

        // Load 0xE, count up through wrap, ovf sticky
        a_ena = 1'b1; a_mode = 3'b001; a_d = 4'hE;
        exp_next(A_Q, 32'hE, "load_e");
        step();
        a_mode = 3'b100;
        exp_now(A_TC, 32'h0, "tc_at_e");
        exp_next(A_Q, 32'hF, "up_f");
        exp_next(A_OVF, 32'h0, "ovf_pre_wrap");
        step();
        exp_now(A_TC, 32'h1, "tc_at_f");
        exp_next(A_Q, 32'h0, "wrap_0");
        exp_next(A_OVF, 32'h1, "ovf_wrap");
        step();
        applied++;
        if (a_q !== 4'h0 || a_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL direct_wrap: q=%0h ovf=%0b", a_q, a_ovf);
        end
        a_mode = 3'b000;
        exp_now(A_TC, 32'h0, "tc_hold");
        exp_next(A_Q, 32'h0, "hold_q");
        exp_next(A_OVF, 32'h1, "ovf_sticky");
        step();
        a_ena = 1'b0; a_mode = 3'b001;
        exp_next(A_OVF, 32'h1, "ovf_dis_hold");
        step();

        // Shift left then right through sin, sout taps
        a_ena = 1'b1; a_mode = 3'b001; a_d = 4'b1001;
        exp_next(A_Q, 32'h9, "load_9");
        exp_next(A_OVF, 32'h0, "ovf_load_clr");
        step();
        a_mode = 3'b010; a_sin = 1'b0;
        exp_now(A_SOUT, 32'h1, "sout_shl");
        exp_next(A_Q, 32'h2, "shl_q");
        step();
        a_mode = 3'b011; a_sin = 1'b1;
        exp_now(A_SOUT, 32'h0, "sout_shr");
        exp_next(A_Q, 32'h9, "shr_q");
        step();
        a_ena = 1'b0;
        exp_now(A_SOUT, 32'h1, "sout_shr_dis");
        exp_next(A_Q, 32'h9, "shr_dis_q");
        step();
        a_ena = 1'b1; a_mode = 3'b000;
        exp_now(A_SOUT, 32'h0, "sout_hold");
        step();

        // Reset mid-count, reserved mode holds, count resumes from INIT
        a_mode = 3'b001; a_d = 4'h3;
        exp_next(A_Q, 32'h3, "load_3");
        step();
        a_mode = 3'b100;
        exp_next(A_Q, 32'h4, "up_4");
        step();
        a_reset = 1'b1;
        exp_next(A_Q, 32'h5, "midrst_q");
        exp_next(A_OVF, 32'h0, "midrst_ovf");
        step();
        a_reset = 1'b0; a_mode = 3'b111;
        exp_next(A_Q, 32'h5, "rsvd_hold");
        step();
        a_mode = 3'b100;
        exp_next(A_Q, 32'h6, "resume_up");
        step();

        // Down-count wrap and clear on the wrapping instance
        a_mode = 3'b110;
        exp_next(A_Q, 32'h0, "clr_q");
        step();
        a_mode = 3'b101;
        exp_now(A_TC, 32'h1, "tc_down0");
        exp_next(A_Q, 32'hF, "down_wrap");
        exp_next(A_OVF, 32'h1, "ovf_down");
        step();
        a_mode = 3'b110;
        exp_next(A_OVF, 32'h0, "ovf_clr");
        step();

        // Saturating instance: underflow and overflow clamp
        b_ena = 1'b1; b_mode = 3'b101;
        exp_now(B_TC, 32'h1, "sat_tc_dn");
        exp_next(B_Q, 32'h0, "sat_dn_q");
        exp_next(B_OVF, 32'h1, "sat_dn_ovf");
        step();
        applied++;
        if (b_q !== 4'h0 || b_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL direct_sat_dn: q=%0h ovf=%0b", b_q, b_ovf);
        end
        b_mode = 3'b110;
        exp_next(B_OVF, 32'h0, "sat_clr_ovf");
        step();
        b_mode = 3'b001; b_d = 4'hF;
        exp_next(B_Q, 32'hF, "sat_load_f");
        step();
        b_mode = 3'b100;
        exp_now(B_TC, 32'h1, "sat_tc_up");
        exp_next(B_Q, 32'hF, "sat_up_q");
        exp_next(B_OVF, 32'h1, "sat_up_ovf");
        step();
        b_mode = 3'b001; b_d = 4'h7;
        exp_next(B_Q, 32'h7, "sat_load_7");
        exp_next(B_OVF, 32'h0, "sat_load_clr");
        step();

        // 8-bit wrap from 0xFE
        c_ena = 1'b1; c_mode = 3'b001; c_d = 8'hFE;
        exp_next(C_Q, 32'hFE, "w8_load");
        step();
        c_mode = 3'b100;
        exp_now(C_TC, 32'h0, "w8_tc_fe");
        exp_next(C_Q, 32'hFF, "w8_up_ff");
        step();
        exp_now(C_TC, 32'h1, "w8_tc_ff");
        exp_next(C_Q, 32'h00, "w8_wrap");
        exp_next(C_OVF, 32'h1, "w8_ovf");
        step();
        applied++;
        if (c_q !== 8'h00 || c_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL direct_w8_wrap: q=%0h ovf=%0b", c_q, c_ovf);
        end
        c_mode = 3'b000;
        exp_next(C_OVF, 32'h1, "w8_ovf_sticky");
        step();

        step();
        @(negedge clk);
        #1;
        while (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            applied++;
            miscompares++;
            $display("FAIL %s: never compared, expected %0h", it.name, it.exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/univ_reg.md
UNIV_REG -- requirements
Module: univ_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning register width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter SATURATE, default 0, meaning 0 = counters wrap, 1 = counters clamp at the limit.
REQ-003 The block SHALL have parameter INIT, default 0, meaning the value loaded into q on reset (WIDTH bits).
REQ-004 Port clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-005 Port reset  input  1  is a synchronous, active-high reset, sampled on the clk rising edge.
REQ-006 Port ena  input  1  is the clock enable; when low, all state holds.
REQ-007 Port mode  input  3  selects the operation (see REQ-011).
REQ-008 Port d  input  WIDTH  is the parallel load data.
REQ-009 Port sin  input  1  is the serial input for shift modes.
REQ-010 Outputs: q  output  WIDTH  register value; sout  output  1  serial out; tc  output  1  terminal count; ovf  output  1  sticky overflow/underflow flag.

Function
REQ-011 With ena=1 and reset=0, q SHALL update per mode on each rising clk edge:
- 000: hold.
- 001: load d.
- 010: shift left, q <= {q[WIDTH-2:0], sin}.
- 011: shift right, q <= {sin, q[WIDTH-1:1]}.
- 100: count up by 1.
- 101: count down by 1.
- 110: clear to 0.
- 111: reserved, behaves as hold.
REQ-012 When ena=0, q and ovf SHALL hold regardless of mode, d and sin.
REQ-013 Count up at q = all-ones SHALL produce q = 0 when SATURATE=0, and q = all-ones (unchanged) when SATURATE=1.
REQ-014 Count down at q = 0 SHALL produce q = all-ones when SATURATE=0, and q = 0 (unchanged) when SATURATE=1.
REQ-015 ovf SHALL be set on the edge where a REQ-013/REQ-014 limit event occurs, for either SATURATE value, and SHALL remain set until cleared.
REQ-016 ovf SHALL be cleared on an enabled edge with mode 001 or 110; it SHALL hold in all other modes.
REQ-017 tc SHALL be combinational and equal 1 when ena=1 and either mode=100 with q all-ones, or mode=101 with q=0; otherwise 0.
REQ-018 sout SHALL be combinational: q[WIDTH-1] in mode 010, q[0] in mode 011, and 0 in all other modes. It is independent of ena.
REQ-019 Latency SHALL be one clock: the effect of an operation is visible on q the cycle after the sampling edge.
REQ-020 Arithmetic SHALL be unsigned modulo 2^WIDTH; no carry out beyond ovf and tc.

Reset
REQ-021 reset=1 at a rising edge SHALL set q = INIT and ovf = 0, overriding ena and mode.
REQ-022 When reset is asserted mid-operation (any mode, any q), the next state SHALL be the reset state; operation resumes from INIT on the first edge with reset=0.
REQ-023 No output SHALL change asynchronously on reset; before the first clk edge, state is undefined.

Verification (WIDTH=4 unless stated)
REQ-024 The bench SHALL check: reset=1, INIT=4'h5 -> after one edge q=4'h5, ovf=0; then ena=0, mode=001, d=4'hA for 3 edges -> q stays 4'h5.
REQ-025 The bench SHALL check: load 4'hE, then mode=100 for 2 edges, SATURATE=0 -> q=4'hF with tc=1 before the 2nd edge; then q=4'h0, ovf=1. A following mode=000 edge -> ovf still 1.
REQ-026 The bench SHALL check: SATURATE=1, q=4'h0, mode=101 -> tc=1; after the edge q=4'h0, ovf=1; then mode=110 edge -> ovf=0.
REQ-027 The bench SHALL check: load 4'b1001, mode=010, sin=0 -> sout=1; after the edge q=4'b0010. Then mode=011, sin=1 -> sout=0; after the edge q=4'b1001.
REQ-028 The bench SHALL check: counting up from 4'h3 with mode=100, assert reset on the 2nd edge -> q=INIT, ovf=0; mode=111 with ena=1 -> q unchanged.
REQ-029 The bench SHALL check: repeat REQ-025 with WIDTH=8, from 8'hFE -> wrap to 8'h00 and ovf=1.
